// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control slice: datapath field codes,
// reset PC and the pipe_ctrl state encodings.
package pipe_ctrl_pkg;

    localparam int unsigned WB_SEL_W        = 2;
    localparam int unsigned MEM_RW_W        = 2;
    localparam int unsigned INST_ADDR_WIDTH = 32;

    localparam logic [WB_SEL_W-1:0] WB_ALU = 2'd0;
    localparam logic [WB_SEL_W-1:0] WB_MEM = 2'd1;
    localparam logic [WB_SEL_W-1:0] WB_PC  = 2'd2;

    localparam logic [MEM_RW_W-1:0] MEM_NONE  = 2'd0;
    localparam logic [MEM_RW_W-1:0] MEM_READ  = 2'd1;
    localparam logic [MEM_RW_W-1:0] MEM_WRITE = 2'd2;

    localparam logic [4:0]                 ZERO_REG      = 5'd0;
    localparam logic [INST_ADDR_WIDTH-1:0] INI_INST_ADDR = 32'h8000_0000;

    localparam logic [1:0] PC_RUN     = 2'd0;
    localparam logic [1:0] PC_LDSTALL = 2'd1;
    localparam logic [1:0] PC_MCWAIT  = 2'd2;

    function automatic logic is_load(input logic [MEM_RW_W-1:0] mem_rw,
                                     input logic [WB_SEL_W-1:0] wb_sel);
        return (mem_rw == MEM_READ) && (wb_sel == WB_MEM);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_det.sv
// Combinational load-use comparator between the ID instruction and the
// load currently sitting in the ID/EX register.
module hazard_det
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0]          id_rs1_raddr,
    input  logic [4:0]          id_rs2_raddr,
    input  logic                id_rs1_ren,
    input  logic                id_rs2_ren,
    input  logic [4:0]          ex_rd_waddr,
    input  logic [WB_SEL_W-1:0] ex_wb_sel,
    input  logic [MEM_RW_W-1:0] ex_mem_rw,
    output logic                load_use
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_rs1_ren && (id_rs1_raddr == ex_rd_waddr);
        rs2_hit  = id_rs2_ren && (id_rs2_raddr == ex_rd_waddr);
        load_use = is_load(ex_mem_rw, ex_wb_sel) && (ex_rd_waddr != ZERO_REG)
                   && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Hold/flush/redirect control for the IF/ID and ID/EX registers.
// Optional multi-cycle timeout enabled by defining PIPE_CTRL_TIMEOUT_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MC_TIMEOUT        = 64,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4:0]                 id_rs1_raddr,
    input  logic [4:0]                 id_rs2_raddr,
    input  logic                       id_rs1_ren,
    input  logic                       id_rs2_ren,
    input  logic [4:0]                 ex_rd_waddr,
    input  logic [WB_SEL_W-1:0]        ex_wb_sel,
    input  logic [MEM_RW_W-1:0]        ex_mem_rw,
    input  logic                       ex_br_taken,
    input  logic [INST_ADDR_WIDTH-1:0] ex_br_addr,
    input  logic                       ex_mc_start,
    input  logic                       ex_mc_done,
    output logic                       hold_pc,
    output logic                       hold_if_id,
    output logic                       hold_id_ex,
    output logic                       flush_if_id,
    output logic                       flush_id_ex,
    output logic                       jump_en,
    output logic [INST_ADDR_WIDTH-1:0] jump_addr,
    output logic [CNT_WIDTH-1:0]       stall_cnt
`ifdef PIPE_CTRL_TIMEOUT_EN
    ,
    output logic                       mc_timeout
`endif
);

    generate
        if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 7 || MC_TIMEOUT == 0) begin : g_bad_param
            $error("pipe_ctrl: parameter out of range");
        end
    endgenerate

    localparam logic [2:0] LD_RELOAD = 3'(LOAD_STALL_CYCLES - 1);

    logic [1:0]                 state, state_nxt;
    logic [2:0]                 ld_cnt, ld_cnt_nxt;
    logic [INST_ADDR_WIDTH-1:0] jaddr_q;
    logic [CNT_WIDTH-1:0]       stall_q;
    logic                       load_use;
    logic                       br_ok;
    logic                       hp_raw, hif_raw, hie_raw, fif_raw, fie_raw, je_raw;

`ifdef PIPE_CTRL_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(MC_TIMEOUT) + 1;
    logic [TO_W-1:0] to_cnt;
    logic            to_hit;
    logic            to_raw;

    assign to_hit = (to_cnt == TO_W'(MC_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            to_cnt <= '0;
        else if (state == PC_MCWAIT && state_nxt == PC_MCWAIT)
            to_cnt <= to_cnt + TO_W'(1);
        else
            to_cnt <= '0;
    end
`endif

    hazard_det u_hazard_det (
        .id_rs1_raddr (id_rs1_raddr),
        .id_rs2_raddr (id_rs2_raddr),
        .id_rs1_ren   (id_rs1_ren),
        .id_rs2_ren   (id_rs2_ren),
        .ex_rd_waddr  (ex_rd_waddr),
        .ex_wb_sel    (ex_wb_sel),
        .ex_mem_rw    (ex_mem_rw),
        .load_use     (load_use)
    );

    // EX cannot hold a resolved branch while a multi-cycle op occupies it.
    assign br_ok = ex_br_taken && (state != PC_MCWAIT);

    always_comb begin
        state_nxt  = state;
        ld_cnt_nxt = ld_cnt;
        hp_raw     = 1'b0;
        hif_raw    = 1'b0;
        hie_raw    = 1'b0;
        fif_raw    = 1'b0;
        fie_raw    = 1'b0;
        je_raw     = 1'b0;
`ifdef PIPE_CTRL_TIMEOUT_EN
        to_raw     = 1'b0;
`endif
        case (state)
            PC_RUN: begin
                if (br_ok) begin
                    je_raw  = 1'b1;
                    fif_raw = 1'b1;
                    fie_raw = 1'b1;
                end else if (ex_mc_start && !ex_mc_done) begin
                    state_nxt = PC_MCWAIT;
                end else if (load_use) begin
                    hp_raw  = 1'b1;
                    hif_raw = 1'b1;
                    fie_raw = 1'b1;
                    if (LOAD_STALL_CYCLES > 1) begin
                        state_nxt  = PC_LDSTALL;
                        ld_cnt_nxt = LD_RELOAD;
                    end
                end
            end
            PC_LDSTALL: begin
                if (br_ok) begin
                    je_raw     = 1'b1;
                    fif_raw    = 1'b1;
                    fie_raw    = 1'b1;
                    state_nxt  = PC_RUN;
                    ld_cnt_nxt = '0;
                end else begin
                    hp_raw     = 1'b1;
                    hif_raw    = 1'b1;
                    fie_raw    = 1'b1;
                    ld_cnt_nxt = ld_cnt - 3'd1;
                    if (ld_cnt_nxt == '0)
                        state_nxt = PC_RUN;
                end
            end
            PC_MCWAIT: begin
                if (ex_mc_done) begin
                    state_nxt = PC_RUN;
`ifdef PIPE_CTRL_TIMEOUT_EN
                end else if (to_hit) begin
                    to_raw    = 1'b1;
                    hp_raw    = 1'b1;
                    hif_raw   = 1'b1;
                    fie_raw   = 1'b1;
                    state_nxt = PC_RUN;
`endif
                end else begin
                    hp_raw  = 1'b1;
                    hif_raw = 1'b1;
                    hie_raw = 1'b1;
                end
            end
            default: begin
                state_nxt  = PC_RUN;
                ld_cnt_nxt = '0;
            end
        endcase
    end

    // Outputs are forced to idle while reset is low; flush beats hold per register.
    assign hold_pc     = rst & hp_raw;
    assign hold_if_id  = rst & hif_raw & ~fif_raw;
    assign hold_id_ex  = rst & hie_raw & ~fie_raw;
    assign flush_if_id = rst & fif_raw;
    assign flush_id_ex = rst & fie_raw;
    assign jump_en     = rst & je_raw;
    assign jump_addr   = !rst ? INI_INST_ADDR : (je_raw ? ex_br_addr : jaddr_q);
    assign stall_cnt   = stall_q;
`ifdef PIPE_CTRL_TIMEOUT_EN
    assign mc_timeout  = rst & to_raw;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= PC_RUN;
            ld_cnt  <= '0;
            jaddr_q <= INI_INST_ADDR;
            stall_q <= '0;
        end else begin
            state  <= state_nxt;
            ld_cnt <= ld_cnt_nxt;
            if (br_ok)
                jaddr_q <= ex_br_addr;
            if (hold_pc)
                stall_q <= stall_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scoreboard bench for pipe_ctrl: one instance with single-bubble
// load stalls, one with three-cycle stalls and an 8-cycle multi-cycle timeout.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1_raddr, id_rs2_raddr, ex_rd_waddr;
    logic        id_rs1_ren, id_rs2_ren;
    logic [1:0]  ex_wb_sel, ex_mem_rw;
    logic        ex_br_taken, ex_mc_start, ex_mc_done;
    logic [31:0] ex_br_addr;

    logic        o1_hp, o1_hif, o1_hie, o1_fif, o1_fie, o1_je, o1_to;
    logic [31:0] o1_ja, o1_cnt;
    logic        o3_hp, o3_hif, o3_hie, o3_fif, o3_fie, o3_je, o3_to;
    logic [31:0] o3_ja, o3_cnt;

    typedef logic [69:0] vec_t;
    vec_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] cnt1 = '0;
    logic [31:0] cnt3 = '0;
    logic        exp_to = 1'b0;

    always #5 clk = ~clk;

    pipe_ctrl #(.LOAD_STALL_CYCLES(1), .MC_TIMEOUT(64), .CNT_WIDTH(32)) u_dut1 (
        .clk(clk), .rst(rst),
        .id_rs1_raddr(id_rs1_raddr), .id_rs2_raddr(id_rs2_raddr),
        .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
        .ex_rd_waddr(ex_rd_waddr), .ex_wb_sel(ex_wb_sel), .ex_mem_rw(ex_mem_rw),
        .ex_br_taken(ex_br_taken), .ex_br_addr(ex_br_addr),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .hold_pc(o1_hp), .hold_if_id(o1_hif), .hold_id_ex(o1_hie),
        .flush_if_id(o1_fif), .flush_id_ex(o1_fie),
        .jump_en(o1_je), .jump_addr(o1_ja), .stall_cnt(o1_cnt)
`ifdef PIPE_CTRL_TIMEOUT_EN
        , .mc_timeout(o1_to)
`endif
    );

    pipe_ctrl #(.LOAD_STALL_CYCLES(3), .MC_TIMEOUT(8), .CNT_WIDTH(32)) u_dut3 (
        .clk(clk), .rst(rst),
        .id_rs1_raddr(id_rs1_raddr), .id_rs2_raddr(id_rs2_raddr),
        .id_rs1_ren(id_rs1_ren), .id_rs2_ren(id_rs2_ren),
        .ex_rd_waddr(ex_rd_waddr), .ex_wb_sel(ex_wb_sel), .ex_mem_rw(ex_mem_rw),
        .ex_br_taken(ex_br_taken), .ex_br_addr(ex_br_addr),
        .ex_mc_start(ex_mc_start), .ex_mc_done(ex_mc_done),
        .hold_pc(o3_hp), .hold_if_id(o3_hif), .hold_id_ex(o3_hie),
        .flush_if_id(o3_fif), .flush_id_ex(o3_fie),
        .jump_en(o3_je), .jump_addr(o3_ja), .stall_cnt(o3_cnt)
`ifdef PIPE_CTRL_TIMEOUT_EN
        , .mc_timeout(o3_to)
`endif
    );

`ifndef PIPE_CTRL_TIMEOUT_EN
    assign o1_to = 1'b0;
    assign o3_to = 1'b0;
`endif

    function automatic vec_t obs(input int sel);
        if (sel == 0)
            return {o1_hp, o1_hif, o1_hie, o1_fif, o1_fie, o1_je, o1_ja, o1_cnt};
        return {o3_hp, o3_hif, o3_hie, o3_fif, o3_fie, o3_je, o3_ja, o3_cnt};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1_raddr = 5'd0; id_rs2_raddr = 5'd0;
        id_rs1_ren   = 1'b0; id_rs2_ren   = 1'b0;
        ex_rd_waddr  = 5'd0; ex_wb_sel    = WB_ALU; ex_mem_rw = MEM_NONE;
        ex_br_taken  = 1'b0; ex_br_addr   = 32'h0;
        ex_mc_start  = 1'b0; ex_mc_done   = 1'b0;
    endtask

    task automatic hazard(input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic ren1, input logic ren2, input logic [4:0] rd);
        idle();
        id_rs1_raddr = rs1; id_rs2_raddr = rs2;
        id_rs1_ren   = ren1; id_rs2_ren  = ren2;
        ex_rd_waddr  = rd;  ex_wb_sel    = WB_MEM; ex_mem_rw = MEM_READ;
    endtask

    task automatic chk(input int sel, input string tag,
                       input logic hp, input logic hif, input logic hie,
                       input logic fif, input logic fie, input logic je,
                       input logic [31:0] ja);
        vec_t e, o;
        logic t;
        exp_q.push_back({hp, hif, hie, fif, fie, je, ja, (sel == 0) ? cnt1 : cnt3});
        #3;
        e = exp_q.pop_front();
        o = obs(sel);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed {hp,hif,hie,fif,fie,je,addr,cnt}=%h expected %h", tag, o, e);
        end
`ifdef PIPE_CTRL_TIMEOUT_EN
        t = (sel == 0) ? o1_to : o3_to;
        n_chk++;
        assert (t === exp_to) else begin
            n_fail++;
            $error("FAIL %s_to: observed mc_timeout=%b expected %b", tag, t, exp_to);
        end
`else
        t = 1'b0;
`endif
        if (hp) begin
            if (sel == 0) cnt1 = cnt1 + 1;
            else          cnt3 = cnt3 + 1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle();
        #1;
        chk(0, "reset_d1", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        chk(1, "reset_d3", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        @(posedge clk); #1 rst = 1'b1;

        // single-bubble load-use instance
        cyc(); idle();                   chk(0, "idle", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); hazard(5, 1, 1, 1, 5);    chk(0, "lu_rs1", 1, 1, 0, 0, 1, 0, INI_INST_ADDR);
        cyc(); idle();                   chk(0, "lu_bubble", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); hazard(1, 5, 1, 1, 5);    chk(0, "lu_rs2", 1, 1, 0, 0, 1, 0, INI_INST_ADDR);
        cyc(); idle();                   chk(0, "lu_rs2_after", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); hazard(0, 1, 1, 0, 0);    chk(0, "rd_zero", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); hazard(5, 5, 0, 0, 5);    chk(0, "ren_off", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); hazard(5, 1, 1, 1, 5); ex_wb_sel = WB_ALU;
                                         chk(0, "wb_alu", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);

        cyc(); idle(); ex_mc_start = 1'b1;
                                         chk(0, "mc_start", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        for (int i = 0; i < 3; i++) begin
            cyc(); idle();               chk(0, "mc_wait", 1, 1, 1, 0, 0, 0, INI_INST_ADDR);
        end
        cyc(); idle(); ex_mc_done = 1'b1;
                                         chk(0, "mc_done", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); idle();                   chk(0, "mc_after", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); idle(); ex_mc_start = 1'b1; ex_mc_done = 1'b1;
                                         chk(0, "mc_same", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); idle();                   chk(0, "mc_same_after", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);

        cyc(); hazard(5, 1, 1, 1, 5); ex_br_taken = 1'b1; ex_br_addr = 32'h8000_0040;
                                         chk(0, "br_over_lu", 0, 0, 0, 1, 1, 1, 32'h8000_0040);
        cyc(); idle();                   chk(0, "br_addr_kept", 0, 0, 0, 0, 0, 0, 32'h8000_0040);
        cyc(); idle(); ex_mc_start = 1'b1;
                                         chk(0, "mc_start2", 0, 0, 0, 0, 0, 0, 32'h8000_0040);
        cyc(); idle(); ex_br_taken = 1'b1; ex_br_addr = 32'h8000_0100;
                                         chk(0, "br_in_mcwait", 1, 1, 1, 0, 0, 0, 32'h8000_0040);
        cyc(); idle(); ex_mc_done = 1'b1;
                                         chk(0, "mc_done2", 0, 0, 0, 0, 0, 0, 32'h8000_0040);

        // three-cycle load-stall instance, reset in the middle of a stall
        cyc(); idle(); rst = 1'b0; cnt1 = '0; cnt3 = '0;
                                         chk(1, "reset2_d3", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); rst = 1'b1;
        cyc(); idle();                   chk(1, "idle3", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); hazard(5, 1, 1, 1, 5);    chk(1, "lu3_c1", 1, 1, 0, 0, 1, 0, INI_INST_ADDR);
        cyc(); idle();                   chk(1, "lu3_c2", 1, 1, 0, 0, 1, 0, INI_INST_ADDR);
        rst = 1'b0; cnt1 = '0; cnt3 = '0;
                                         chk(1, "rst_mid_stall", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); rst = 1'b1;
        cyc(); idle();                   chk(1, "post_rst", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); hazard(5, 1, 1, 1, 5);    chk(1, "lu3b_c1", 1, 1, 0, 0, 1, 0, INI_INST_ADDR);
        cyc(); idle();                   chk(1, "lu3b_c2", 1, 1, 0, 0, 1, 0, INI_INST_ADDR);
        cyc(); idle();                   chk(1, "lu3b_c3", 1, 1, 0, 0, 1, 0, INI_INST_ADDR);
        cyc(); idle();                   chk(1, "lu3b_end", 0, 0, 0, 0, 0, 0, INI_INST_ADDR);
        cyc(); hazard(1, 5, 0, 1, 5);    chk(1, "lu3c_c1", 1, 1, 0, 0, 1, 0, INI_INST_ADDR);
        cyc(); idle();                   chk(1, "lu3c_c2", 1, 1, 0, 0, 1, 0, INI_INST_ADDR);
        cyc(); idle(); ex_br_taken = 1'b1; ex_br_addr = 32'h8000_0080;
                                         chk(1, "br_in_ldstall", 0, 0, 0, 1, 1, 1, 32'h8000_0080);
        cyc(); idle();                   chk(1, "br_ldstall_after", 0, 0, 0, 0, 0, 0, 32'h8000_0080);

`ifdef PIPE_CTRL_TIMEOUT_EN
        cyc(); idle(); ex_mc_start = 1'b1;
                                         chk(1, "to_start", 0, 0, 0, 0, 0, 0, 32'h8000_0080);
        for (int k = 0; k < 7; k++) begin
            cyc(); idle();               chk(1, "to_wait", 1, 1, 1, 0, 0, 0, 32'h8000_0080);
        end
        cyc(); idle(); exp_to = 1'b1;
                                         chk(1, "to_fire", 1, 1, 0, 0, 1, 0, 32'h8000_0080);
        exp_to = 1'b0;
        cyc(); idle();                   chk(1, "to_after", 0, 0, 0, 0, 0, 0, 32'h8000_0080);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
